// File: rtl/axis_frame_source.sv
// AXI-Stream master: buffers samples in a FIFO and sends FRAME_LEN-beat frames with tlast.
// Define AXIS_FRAME_SOURCE_PAD_EN to send zero beats on underrun instead of stalling.
module axis_frame_source #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int FIFO_DEPTH             = 16,
  parameter int FRAME_LEN              = 256
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                wr_valid,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   wr_data,
  output logic                                wr_ready,
  input  logic                                start,
  output logic                                busy,
  output logic                                frame_done,
  output logic [15:0]                         underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);
  // state  | meaning
  // IDLE   | waiting for start; FIFO may fill, nothing is transmitted
  // ACTIVE | loading and sending beats until the tlast handshake
  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic [CW-1:0]       beats_left_q, beats_left_d;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DW-1:0]       tdata_q, tdata_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         underrun_q, underrun_d;
  logic                slot_free, hs, want, fifo_empty, push, pop, underrun, load;

  assign wr_ready        = (level_q != LVL_FULL);
  assign busy            = (state_q == ACTIVE);
  assign frame_done      = frame_done_q;
  assign underrun_count  = underrun_q;
  assign fifo_level      = level_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = {(DW/8){tvalid_q}};

  always_comb begin
    slot_free  = !tvalid_q || m00_axis_tready;
    hs         = tvalid_q && m00_axis_tready;
    want       = (state_q == ACTIVE) && slot_free && (beats_left_q != '0);
    fifo_empty = (level_q == '0);
    push       = wr_valid && wr_ready;
    pop        = want && !fifo_empty;
    underrun   = want && fifo_empty;
`ifdef AXIS_FRAME_SOURCE_PAD_EN
    load       = want;
`else
    load       = pop;
`endif

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    beats_left_d = beats_left_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;

    if (hs) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    // A zero beat is only ever loaded in pad mode, where load can fire with an empty FIFO
    if (load) begin
      tvalid_d     = 1'b1;
      tlast_d      = (beats_left_q == CW'(1));
      tdata_d      = pop ? mem_q[rd_ptr_q] : '0;
      beats_left_d = beats_left_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ACTIVE;
          beats_left_d = CW'(FRAME_LEN);
        end
      end
      ACTIVE: begin
        if (hs && tlast_q) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (underrun && (underrun_q != 16'hFFFF)) underrun_d = underrun_q + 16'd1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      beats_left_q <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      beats_left_q <= beats_left_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: queue-based cycle model plus directed literal checks.
module tb_axis_frame_source;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          tready = 1'b0;
  logic          wr_ready, busy, frame_done, tvalid, tlast;
  logic [15:0]   underrun_count;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;

  axis_frame_source #(
    .C_M00_AXIS_TDATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN(FLEN)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_areset(rst),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .start(start),
    .busy(busy),
    .frame_done(frame_done),
    .underrun_count(underrun_count),
    .fifo_level(fifo_level),
    .m00_axis_tready(tready),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tlast(tlast),
    .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame progress as a count of beats loaded so far
  logic [63:0] m_q[$];
  bit          m_active, m_v, m_l, m_done;
  int          m_loaded, m_under;
  logic [63:0] m_d;

  always @(posedge clk) begin
    bit push, hs, free;
    push   = wr_valid && (m_q.size() != DEPTH);
    hs     = m_v && tready;
    free   = !m_v || tready;
    m_done = 1'b0;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0; m_v = 1'b0; m_l = 1'b0; m_d = '0;
      m_loaded = 0; m_under = 0;
    end else begin
      if (!m_active) begin
        if (start) begin m_active = 1'b1; m_loaded = 0; end
      end else if (hs && m_l) begin
        m_active = 1'b0; m_v = 1'b0; m_l = 1'b0; m_done = 1'b1;
      end else begin
        if (hs) m_v = 1'b0;
        if (free && m_loaded < FLEN) begin
          if (m_q.size() != 0) begin
            m_d = m_q.pop_front(); m_v = 1'b1; m_loaded++; m_l = (m_loaded == FLEN);
          end else begin
            if (m_under < 65535) m_under++;
`ifdef AXIS_FRAME_SOURCE_PAD_EN
            m_d = '0; m_v = 1'b1; m_loaded++; m_l = (m_loaded == FLEN);
`endif
          end
        end
      end
      if (push) m_q.push_back(wr_data);
    end
  end

  bit          chk_en = 1'b0;
  logic [63:0] beats[$];
  int          n_done = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("tvalid", 64'(tvalid), 64'(m_v));
      if (m_v) begin
        check("tdata", tdata, m_d);
        check("tlast", 64'(tlast), 64'(m_l));
      end
      check("tstrb", 64'(tstrb), m_v ? 64'hFF : 64'h0);
      check("busy", 64'(busy), 64'(m_active));
      check("frame_done", 64'(frame_done), 64'(m_done));
      check("underrun_count", 64'(underrun_count), 64'(m_under));
      check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      check("wr_ready", 64'(wr_ready), 64'(m_q.size() != DEPTH));
      if (tvalid && tready) beats.push_back(tdata);
      if (frame_done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write(logic [63:0] d);
    wr_valid = 1'b1; wr_data = d; tick(); wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_frames(int target, int budget, string name);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin tick(); k++; end
    check(name, 64'(n_done), 64'(target));
  endtask

  task automatic check_frame(string name, int b0, logic [63:0] e0, logic [63:0] e1,
                             logic [63:0] e2, logic [63:0] e3);
    logic [63:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({name, " beat count"}, 64'(beats.size() - b0), 64'd4);
    for (int k = 0; k < 4; k++)
      if (b0 + k < beats.size()) check({name, " beat"}, beats[b0 + k], e[k]);
  endtask

  initial begin
    int b0, d0, k;
    rst = 1'b1; tick(); tick(); rst = 1'b0; chk_en = 1'b1;
    check("reset tvalid", 64'(tvalid), 64'd0);
    check("reset tdata", tdata, 64'd0);
    check("reset tstrb", 64'(tstrb), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset fifo_level", 64'(fifo_level), 64'd0);
    check("reset wr_ready", 64'(wr_ready), 64'd1);
    check("reset underrun", 64'(underrun_count), 64'd0);

    // Basic frame at full throughput
    tready = 1'b1;
    for (int i = 1; i <= 4; i++) write(64'(i * 'h11));
    b0 = beats.size(); d0 = n_done;
    pulse_start();
    check("t1 busy after start", 64'(busy), 64'd1);
    check("t1 tvalid on ACTIVE entry", 64'(tvalid), 64'd0);
    tick();
    check("t1 first tvalid", 64'(tvalid), 64'd1);
    check("t1 first tdata", tdata, 64'h11);
    wait_frames(d0 + 1, 20, "t1 frame_done");
    tick(); tick();
    check_frame("t1", b0, 64'h11, 64'h22, 64'h33, 64'h44);
    check("t1 one frame_done", 64'(n_done - d0), 64'd1);
    check("t1 fifo_level", 64'(fifo_level), 64'd0);
    check("t1 busy after", 64'(busy), 64'd0);

    // Backpressure, full FIFO, dropped write
    tready = 1'b0;
    for (int i = 1; i <= 4; i++) write(64'(i * 'h11));
    check("t2 wr_ready full", 64'(wr_ready), 64'd0);
    write(64'h55);
    check("t2 level after dropped write", 64'(fifo_level), 64'd4);
    b0 = beats.size(); d0 = n_done;
    pulse_start(); tick();
    for (int i = 0; i < 10; i++) begin
      check("t2 held tvalid", 64'(tvalid), 64'd1);
      check("t2 held tdata", tdata, 64'h11);
      tick();
    end
    tready = 1'b1;
    wait_frames(d0 + 1, 20, "t2 frame_done");
    tick(); tick();
    check_frame("t2", b0, 64'h11, 64'h22, 64'h33, 64'h44);
    check("t2 fifo_level", 64'(fifo_level), 64'd0);

`ifndef AXIS_FRAME_SOURCE_PAD_EN
    // Underrun mid-frame: two samples queued, the rest arrive late
    write(64'h11); write(64'h22);
    b0 = beats.size(); d0 = n_done;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) check("t3 tvalid gap", 64'(tvalid), 64'd0);
    end
    write(64'h33); write(64'h44);
    wait_frames(d0 + 1, 20, "t3 frame_done");
    tick();
    check_frame("t3", b0, 64'h11, 64'h22, 64'h33, 64'h44);
    check("t3 underrun_count", 64'(underrun_count), 64'd5);
`else
    // Padding: one sample queued, the rest of the frame is zero beats
    rst = 1'b1; tick(); rst = 1'b0;
    write(64'h11);
    b0 = beats.size(); d0 = n_done;
    pulse_start();
    wait_frames(d0 + 1, 20, "pad frame_done");
    tick();
    check_frame("pad", b0, 64'h11, 64'h0, 64'h0, 64'h0);
    check("pad underrun_count", 64'(underrun_count), 64'd3);
`endif

    // start while ACTIVE is ignored
    for (int i = 1; i <= 4; i++) write(64'(i * 'h10 + 1));
    b0 = beats.size(); d0 = n_done;
    pulse_start(); tick(); pulse_start();
    wait_frames(d0 + 1, 20, "t4 frame_done");
    for (int i = 0; i < 10; i++) tick();
    check_frame("t4", b0, 64'h11, 64'h21, 64'h31, 64'h41);
    check("t4 one frame_done", 64'(n_done - d0), 64'd1);
    check("t4 busy after", 64'(busy), 64'd0);

    // Reset mid-frame after the second handshake
    for (int i = 1; i <= 4; i++) write(64'(i * 'h11));
    b0 = beats.size(); d0 = n_done;
    pulse_start();
    k = 0;
    while (beats.size() - b0 < 2 && k < 20) begin tick(); k++; end
    check("t5 two beats before reset", 64'(beats.size() - b0), 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5 tvalid after reset", 64'(tvalid), 64'd0);
    check("t5 fifo_level after reset", 64'(fifo_level), 64'd0);
    check("t5 wr_ready after reset", 64'(wr_ready), 64'd1);
    check("t5 frame_done after reset", 64'(frame_done), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t5 no frame_done", 64'(n_done - d0), 64'd0);
    for (int i = 0; i < 4; i++) write(64'hA0 + 64'(i));
    b0 = beats.size(); d0 = n_done;
    pulse_start();
    wait_frames(d0 + 1, 20, "t5 clean frame_done");
    tick();
    check_frame("t5 clean", b0, 64'hA0, 64'hA1, 64'hA2, 64'hA3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_data  = {$urandom(), $urandom()};
      tready   = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      tick();
    end
    wr_valid = 1'b0; start = 1'b0; rst = 1'b0; tready = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- AXI-Stream master that buffers 64-bit samples in a small FIFO and transmits them downstream as fixed-length frames, with tlast on the final beat.
- It is the active transmitting counterpart to the team's passive stream monitors. It drives the same m00_axis interface those monitors snoop, and it honours backpressure.
- Sample packing matches the CORDIC stream: angle in [63:32], magnitude in [31:0]. The block passes tdata through unmodified.

Parameters:
- C_M00_AXIS_TDATA_WIDTH, 64, stream data width; also the width of wr_data.
- FIFO_DEPTH, 16, sample buffer entries; must be a power of 2 and at least 2.
- FRAME_LEN, 256, beats per frame; must be at least 1.

Ports:
- s00_axis_aclk  input  1  sole clock; all logic on the rising edge.
- s00_axis_areset  input  1  synchronous reset, active-high.
- wr_valid  input  1  sample-write request.
- wr_data  input  C_M00_AXIS_TDATA_WIDTH  sample to enqueue.
- wr_ready  output  1  FIFO can accept a write.
- start  input  1  single-cycle request to send one frame.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the tlast handshake.
- underrun_count  output  16  saturating count of stall cycles caused by an empty FIFO mid-frame.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- m00_axis_tready  input  1  downstream ready.
- m00_axis_tvalid  output  1  beat valid.
- m00_axis_tlast  output  1  last beat of the frame.
- m00_axis_tdata  output  C_M00_AXIS_TDATA_WIDTH  beat data.
- m00_axis_tstrb  output  C_M00_AXIS_TDATA_WIDTH/8  all ones whenever tvalid is high; 0 otherwise.

Behaviour:
- Reset values (applied at the first edge with s00_axis_areset=1):
  - tvalid, tlast, tdata, tstrb, busy, frame_done, underrun_count, fifo_level all 0; wr_ready 1.
  - FIFO flushed; FSM in IDLE.
  - Reset mid-frame aborts the frame: no tlast, no frame_done.
- Handshakes:
  - Write accepted when wr_valid & wr_ready.
  - wr_ready = (fifo_level != FIFO_DEPTH). It does not depend on a same-cycle read, so a write to a full FIFO is refused even if a pop occurs that cycle.
  - Beat transferred when m00_axis_tvalid & m00_axis_tready.
  - Once tvalid is high, tdata and tlast stay stable, and tvalid stays high, until the handshake.
- FSM:
  - IDLE: start=1 → ACTIVE; beat counter cleared; busy=1 from the next cycle.
  - ACTIVE:
    - Output register loads a FIFO head when the FIFO is non-empty, fewer than FRAME_LEN beats have been loaded, and the register is empty or being consumed this cycle.
    - Yields one beat per cycle at full throughput.
    - First tvalid appears one cycle after entering ACTIVE if the FIFO is non-empty.
    - tlast=1 on the beat loaded as number FRAME_LEN.
    - On the tlast handshake → IDLE; busy=0 and frame_done=1 in the next cycle.
  - start while ACTIVE is ignored and not queued.
- Underrun:
  - Each ACTIVE cycle where the register is empty or being consumed, beats remain to load, and the FIFO is empty counts +1 to underrun_count.
  - underrun_count saturates at 0xFFFF.
  - tvalid drops and the frame resumes when data arrives.
- FIFO:
  - No write→read bypass; a sample written to an empty FIFO is loadable the following cycle.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- IDLE with a full FIFO: nothing is transmitted and data is held.

Optional Feature:
- Macro: AXIS_FRAME_SOURCE_PAD_EN.
- Defined:
  - On an underrun condition, the output register loads an all-zero beat instead of stalling. That beat counts toward FRAME_LEN and may carry tlast.
  - underrun_count still increments once per pad beat, so frames always complete in FRAME_LEN consecutive tready cycles.
- Undefined: stall behaviour exactly as in Behaviour.

Test Plan:
- FRAME_LEN=4, FIFO_DEPTH=4; write 0x11..0x44; pulse start; tready=1 → four beats on consecutive cycles, first one cycle after ACTIVE; tlast only on 0x44; frame_done pulses once; fifo_level=0; busy=0.
- Fill 4 entries with tready=0 → tvalid held high with tdata=0x11 stable over 10 cycles; wr_ready=0 at level 4; a write attempted while full is dropped; release tready → 0x11..0x44 in order.
- Start with 2 samples queued, write 2 more 5 cycles later → tvalid gap; underrun_count=5 (exact per the rule); frame completes with tlast on the 4th beat.
- Pulse start again during ACTIVE → still exactly 4 beats and one frame_done; busy=0 afterward.
- Assert reset after the 2nd handshake → next cycle tvalid=0, fifo_level=0, wr_ready=1, no frame_done; a new start after reset then sends a clean frame.
- With AXIS_FRAME_SOURCE_PAD_EN defined, start with 1 sample → beats 0x11, 0, 0, 0 on consecutive cycles, tlast on the 4th; underrun_count=3.
